// File: rtl/rpn_eval_pkg.sv
// Shared constants for the RPN evaluator: token-type codes, opcodes and FSM state encoding.
package rpn_eval_pkg;

  // Token types carried on tok_type_i
  localparam logic [1:0] TokOperand  = 2'b00;
  localparam logic [1:0] TokOperator = 2'b01;
  localparam logic [1:0] TokEmit     = 2'b10;
  localparam logic [1:0] TokRsvd     = 2'b11;

  // Opcodes carried in tok_data_i[2:0]; a is the deeper operand
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;

  typedef enum logic [3:0] {
    StIdle,
    StPush,
    StPopB,
    StCapB,
    StPopA,
    StCapA,
    StEPop,
    StECap,
    StErr
  } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator datapath for the RPN evaluator.
// Opcode 101 (MUL) exists only when RPN_EVAL_MUL_EN is defined; otherwise it is illegal.
module rpn_alu
  import rpn_eval_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  // Decode the opcode; every result wraps modulo 2^WIDTH
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OpAdd: result_o = a_i + b_i;
      OpSub: result_o = a_i - b_i;
      OpAnd: result_o = a_i & b_i;
      OpOr:  result_o = a_i | b_i;
      OpXor: result_o = a_i ^ b_i;
`ifdef RPN_EVAL_MUL_EN
      OpMul: result_o = a_i * b_i;
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// RPN expression evaluator sequencing an external stack through push/pop strobes.
// Optional feature: define RPN_EVAL_MUL_EN to enable opcode 101 (MUL).
module rpn_eval
  import rpn_eval_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             tok_valid_i,
  output logic             tok_ready_o,
  input  logic [1:0]       tok_type_i,
  input  logic [WIDTH-1:0] tok_data_i,
  output logic             res_valid_o,
  output logic [WIDTH-1:0] res_data_o,
  output logic             err_o,
  output logic             stk_push_o,
  output logic [WIDTH-1:0] stk_din_o,
  output logic             stk_pop_o,
  input  logic [WIDTH-1:0] stk_dout_i,
  input  logic             stk_full_i,
  input  logic             stk_empty_i
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] din_q;
  logic [2:0]       op_q;
  logic             push_alu_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_valid_q;

  logic             tok_accept;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;

  assign tok_accept = tok_valid_i && (state_q == StIdle);
  // In IDLE the ALU only screens the incoming opcode; later it evaluates the latched one
  assign alu_op     = (state_q == StIdle) ? tok_data_i[2:0] : op_q;

  rpn_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (alu_op),
    .result_o  (alu_result),
    .illegal_o (alu_illegal)
  );

  // Next-state and strobe decode; pops are withheld whenever the stack reports empty
  always_comb begin
    state_d     = state_q;
    tok_ready_o = 1'b0;
    stk_push_o  = 1'b0;
    stk_pop_o   = 1'b0;
    stk_din_o   = '0;
    err_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tok_ready_o = 1'b1;
        if (tok_valid_i) begin
          case (tok_type_i)
            TokOperand:  state_d = stk_full_i ? StErr : StPush;
            TokOperator: state_d = alu_illegal ? StErr : StPopB;
            TokEmit:     state_d = StEPop;
            default:     state_d = StErr;
          endcase
        end
      end
      StPush: begin
        stk_push_o = 1'b1;
        stk_din_o  = push_alu_q ? alu_result : din_q;
        state_d    = StIdle;
      end
      StPopB: begin
        if (stk_empty_i) begin
          state_d = StErr;
        end else begin
          stk_pop_o = 1'b1;
          state_d   = StCapB;
        end
      end
      StCapB: state_d = StPopA;
      StPopA: begin
        if (stk_empty_i) begin
          state_d = StErr;
        end else begin
          stk_pop_o = 1'b1;
          state_d   = StCapA;
        end
      end
      StCapA: state_d = StPush;
      StEPop: begin
        if (stk_empty_i) begin
          state_d = StErr;
        end else begin
          stk_pop_o = 1'b1;
          state_d   = StECap;
        end
      end
      StECap: state_d = StIdle;
      StErr:  err_o = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  // State register plus operand/result capture
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      din_q       <= '0;
      op_q        <= '0;
      push_alu_q  <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tok_accept) begin
        din_q      <= tok_data_i;
        op_q       <= tok_data_i[2:0];
        push_alu_q <= (tok_type_i == TokOperator);
      end
      if (state_q == StCapB) b_q <= stk_dout_i;
      if (state_q == StCapA) a_q <= stk_dout_i;
      res_valid_q <= (state_q == StECap);
      if (state_q == StECap) res_data_q <= stk_dout_i;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Self-checking bench for rpn_eval with an 8-deep stack model and a queue-based RPN reference.
// Define RPN_EVAL_MUL_EN consistently for bench and RTL to exercise the MUL opcode.
module tb_rpn_eval;
  import rpn_eval_pkg::*;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         tok_valid_i = 1'b0;
  logic         tok_ready_o;
  logic [1:0]   tok_type_i = 2'b00;
  logic [W-1:0] tok_data_i = '0;
  logic         res_valid_o;
  logic [W-1:0] res_data_o;
  logic         err_o;
  logic         stk_push_o;
  logic [W-1:0] stk_din_o;
  logic         stk_pop_o;
  logic [W-1:0] stk_dout_i;
  logic         stk_full_i;
  logic         stk_empty_i;

  int total = 0;
  int bad = 0;

  rpn_eval #(
    .WIDTH (W)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .tok_valid_i (tok_valid_i),
    .tok_ready_o (tok_ready_o),
    .tok_type_i  (tok_type_i),
    .tok_data_i  (tok_data_i),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .err_o       (err_o),
    .stk_push_o  (stk_push_o),
    .stk_din_o   (stk_din_o),
    .stk_pop_o   (stk_pop_o),
    .stk_dout_i  (stk_dout_i),
    .stk_full_i  (stk_full_i),
    .stk_empty_i (stk_empty_i)
  );

  always #5 clk_i = ~clk_i;

  // 8-deep stack model: top appears on stk_dout_i the cycle after a pop
  logic [W-1:0] mem [8];
  int           cnt;
  assign stk_full_i  = (cnt == 8);
  assign stk_empty_i = (cnt == 0);

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt        <= 0;
      stk_dout_i <= '0;
    end else if (stk_pop_o && cnt > 0) begin
      stk_dout_i <= mem[cnt-1];
      cnt        <= cnt - 1;
    end else if (stk_push_o && cnt < 8) begin
      mem[cnt] <= stk_din_o;
      cnt      <= cnt + 1;
    end
  end

  // Monitor: strobe counters and result log, sampled on the falling edge
  int           push_cnt = 0;
  int           pop_cnt = 0;
  int           both_cnt = 0;
  int           res_pulses = 0;
  logic [W-1:0] res_log [1024];

  always @(negedge clk_i) begin
    if (stk_push_o) push_cnt++;
    if (stk_pop_o) pop_cnt++;
    if (stk_push_o && stk_pop_o) both_cnt++;
    if (res_valid_o && res_pulses < 1024) begin
      res_log[res_pulses] = res_data_o;
      res_pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Reference operator semantics, a being the deeper operand
  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      default: return a * b;
    endcase
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (tok_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [W-1:0] d);
    bit ok;
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_wait got=0 want=1 (type=%0d data=%h)", t, d);
    end
    tok_valid_i = 1'b1;
    tok_type_i  = t;
    tok_data_i  = d;
    @(posedge clk_i);
    #1;
    tok_valid_i = 1'b0;
  endtask

  task automatic emit_check(input string name, input logic [W-1:0] exp);
    int n0;
    bit ok;
    n0 = res_pulses;
    send(TokEmit, '0);
    wait_ready(ok);
    @(negedge clk_i);
    total++;
    if (res_pulses - n0 !== 1) begin
      bad++;
      $display("FAIL %s_pulses got=%0d want=1", name, res_pulses - n0);
    end else begin
      total++;
      if (res_log[n0] !== exp) begin
        bad++;
        $display("FAIL %s_data got=%h want=%h", name, res_log[n0], exp);
      end
    end
  endtask

  task automatic do_reset();
    tok_valid_i = 1'b0;
    reset_n_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    tok_valid_i = 1'b0;
    reset_n_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({err_o, res_valid_o, stk_push_o, stk_pop_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {err_o, res_valid_o, stk_push_o, stk_pop_o});
    end
    total++;
    if (res_data_o !== '0 || stk_din_o !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=00/00", res_data_o, stk_din_o);
    end
    reset_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (tok_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", tok_ready_o);
    end
  endtask

  task automatic test_add();
    do_reset();
    send(TokOperand, 8'h03);
    send(TokOperand, 8'h05);
    send(TokOperator, {5'b0, OpAdd});
    emit_check("add", 8'h08);
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL add_err got=%b want=0", err_o);
    end
  endtask

  task automatic test_sub_xor();
    do_reset();
    send(TokOperand, 8'h02);
    send(TokOperand, 8'h07);
    send(TokOperator, {5'b0, OpSub});
    emit_check("sub", 8'hFB);
    send(TokOperand, 8'hF0);
    send(TokOperand, 8'h3C);
    send(TokOperator, {5'b0, OpXor});
    emit_check("xor", 8'hCC);
  endtask

  task automatic test_random();
    logic [W-1:0] model[$];
    logic [W-1:0] a, b, v;
    int           k, op, maxop;
`ifdef RPN_EVAL_MUL_EN
    maxop = 5;
`else
    maxop = 4;
`endif
    do_reset();
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (model.size() >= 2 && (k < 4 || model.size() == 8)) begin
        op = $urandom_range(0, maxop);
        b  = model.pop_back();
        a  = model.pop_back();
        model.push_back(ref_op(op, a, b));
        send(TokOperator, W'(op));
      end else if (model.size() >= 1 && k < 6) begin
        v = model.pop_back();
        emit_check("rand_emit", v);
      end else begin
        v = W'($urandom_range(0, 255));
        model.push_back(v);
        send(TokOperand, v);
      end
    end
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL rand_err got=%b want=0", err_o);
    end
  endtask

  task automatic test_mul();
    int p0;
    do_reset();
    send(TokOperand, 8'h10);
    send(TokOperand, 8'h11);
`ifdef RPN_EVAL_MUL_EN
    send(TokOperator, {5'b0, OpMul});
    emit_check("mul", 8'h10);
`else
    p0 = pop_cnt;
    send(TokOperator, {5'b0, OpMul});
    repeat (3) @(negedge clk_i);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL mul_undef_err got=%b want=1", err_o);
    end
    total++;
    if (pop_cnt - p0 !== 0) begin
      bad++;
      $display("FAIL mul_undef_pops got=%0d want=0", pop_cnt - p0);
    end
`endif
  endtask

  task automatic test_underflow();
    int p0, hi;
    do_reset();
    p0 = pop_cnt;
    send(TokOperand, 8'h01);
    send(TokOperator, {5'b0, OpAdd});
    repeat (8) @(negedge clk_i);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL underflow_err got=%b want=1", err_o);
    end
    total++;
    if (pop_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL underflow_pops got=%0d want=1", pop_cnt - p0);
    end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (tok_ready_o || stk_push_o || stk_pop_o) hi++;
    end
    total++;
    if (hi !== 0) begin
      bad++;
      $display("FAIL err_hold got=%0d want=0 (cycles with ready/strobe)", hi);
    end
    reset_n_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err_o);
    end
    reset_n_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (tok_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL err_ready_after_reset got=%b want=1", tok_ready_o);
    end
  endtask

  task automatic test_full();
    int p0;
    do_reset();
    p0 = push_cnt;
    for (int i = 0; i < 8; i++) send(TokOperand, W'(i + 1));
    send(TokOperand, 8'h99);
    repeat (3) @(negedge clk_i);
    total++;
    if (push_cnt - p0 !== 8) begin
      bad++;
      $display("FAIL full_pushes got=%0d want=8", push_cnt - p0);
    end
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL full_err got=%b want=1", err_o);
    end
  endtask

  task automatic test_reset_mid();
    int p0, q0;
    do_reset();
    send(TokOperand, 8'h55);
    emit_check("pre_mid", 8'h55);
    send(TokOperand, 8'h04);
    send(TokOperand, 8'h06);
    send(TokOperator, {5'b0, OpAdd});
    // now in POPB; advance one edge into CAPB
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    #1;
    total++;
    if ({err_o, res_valid_o, stk_push_o, stk_pop_o} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_flags got=%b want=0000",
               {err_o, res_valid_o, stk_push_o, stk_pop_o});
    end
    total++;
    if (res_data_o !== '0 || stk_din_o !== '0) begin
      bad++;
      $display("FAIL mid_reset_data got=%h/%h want=00/00", res_data_o, stk_din_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    p0 = push_cnt;
    q0 = pop_cnt;
    repeat (4) @(negedge clk_i);
    total++;
    if (push_cnt - p0 + pop_cnt - q0 !== 0) begin
      bad++;
      $display("FAIL mid_reset_strobes got=%0d want=0", push_cnt - p0 + pop_cnt - q0);
    end
    total++;
    if (tok_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_ready got=%b want=1", tok_ready_o);
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL push_pop_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_random();
    test_mul();
    test_underflow();
    test_full();
    test_reset_mid();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
